muldiv_unit: RTL and testbench

Iterative 64-bit RV64M multiply/divide execution unit, downstream of the register file. It consumes the two read-port operands (rs1/rs2 data) on a start pulse, computes over many cycles, and returns a 64-bit result with its destination-register tag for the write-back path into the register file write port. Single-issue; the control path stalls while `busy` is high.

---
 rtl/muldiv_unit.sv | 167 ++++++++++++++++
 tb/tb_muldiv_unit.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Iterative RV64M multiply/divide unit: radix-2 shift-add multiply, restoring divide, 65-cycle latency.
// Optional MULDIV_FASTPATH_EN: divide-by-zero / zero-multiplier / signed overflow complete in one cycle.
module muldiv_unit #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic [4:0]      rd_in,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic [4:0]      rd_out
);
    localparam int CW = $clog2(XLEN);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

    state_t              state, state_next;
    logic                accept;
    logic [2:0]          fn;
    logic [4:0]          rd_q;
    logic [XLEN-1:0]     opnd;
    logic [2*XLEN-1:0]   p;
    logic [CW-1:0]       cnt;
    logic                neg_res, neg_rem, b_zero, fast_q;

    logic                a_signed, b_signed, a_neg, b_neg, is_div;
    logic [XLEN-1:0]     a_mag, b_mag;
    logic                fast_hit;
    logic [XLEN-1:0]     fast_val;
    logic [XLEN:0]       mul_sum, rem_sh, rem_diff;
    logic                q_bit;
    logic [2*XLEN-1:0]   p_step, prod;
    logic [XLEN-1:0]     quo, rem, fix_val;

    always_comb begin
        a_signed = (funct3 == 3'b001) || (funct3 == 3'b010) ||
                   (funct3 == 3'b100) || (funct3 == 3'b110);
        b_signed = (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110);
        a_neg    = a_signed & op_a[XLEN-1];
        b_neg    = b_signed & op_b[XLEN-1];
        a_mag    = a_neg ? -op_a : op_a;
        b_mag    = b_neg ? -op_b : op_b;
        is_div   = funct3[2];
    end

`ifdef MULDIV_FASTPATH_EN
    logic ovf;
    always_comb begin
        ovf      = ((funct3 == 3'b100) || (funct3 == 3'b110)) &&
                   (op_a == {1'b1, {(XLEN-1){1'b0}}}) && (op_b == '1);
        fast_hit = (op_b == '0) || ovf;
        fast_val = '0;
        case (funct3)
            3'b100:  fast_val = ovf ? op_a : '1;
            3'b101:  fast_val = '1;
            3'b110:  fast_val = ovf ? '0 : op_a;
            3'b111:  fast_val = op_a;
            default: fast_val = '0;
        endcase
    end
`else
    always_comb begin
        fast_hit = 1'b0;
        fast_val = '0;
    end
`endif

    // p holds {acc, multiplier} for multiply and {remainder, dividend/quotient} for divide
    always_comb begin
        mul_sum  = {1'b0, p[2*XLEN-1:XLEN]} + (p[0] ? {1'b0, opnd} : '0);
        rem_sh   = {p[2*XLEN-1:XLEN], p[XLEN-1]};
        rem_diff = rem_sh - {1'b0, opnd};
        q_bit    = (rem_sh >= {1'b0, opnd});
        if (fn[2])
            p_step = {(q_bit ? rem_diff[XLEN-1:0] : rem_sh[XLEN-1:0]), p[XLEN-2:0], q_bit};
        else
            p_step = {mul_sum, p[XLEN-1:1]};
    end

    always_comb begin
        prod    = neg_res ? -p : p;
        quo     = p[XLEN-1:0];
        rem     = p[2*XLEN-1:XLEN];
        fix_val = '0;
        case (fn)
            3'b000:  fix_val = prod[XLEN-1:0];
            3'b001,
            3'b010,
            3'b011:  fix_val = prod[2*XLEN-1:XLEN];
            3'b100:  fix_val = b_zero ? '1 : (neg_res ? -quo : quo);
            3'b101:  fix_val = b_zero ? '1 : quo;
            3'b110:  fix_val = neg_rem ? -rem : rem;
            default: fix_val = rem;
        endcase
        if (fast_q)
            fix_val = p[XLEN-1:0];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_next;
    end

    // Fast-path ops pass through FIX with busy low so done still lands one edge after start
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        case (state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    accept     = 1'b1;
                    state_next = fast_hit ? S_FIX : S_CALC;
                end else if (state == S_DONE) begin
                    state_next = S_IDLE;
                end
            end
            S_CALC:  if (cnt == '0) state_next = S_FIX;
            S_FIX:   state_next = S_DONE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy    <= 1'b0;
            done    <= 1'b0;
            result  <= '0;
            rd_out  <= '0;
            fn      <= '0;
            rd_q    <= '0;
            opnd    <= '0;
            p       <= '0;
            cnt     <= '0;
            neg_res <= 1'b0;
            neg_rem <= 1'b0;
            b_zero  <= 1'b0;
            fast_q  <= 1'b0;
        end else begin
            busy <= (state_next == S_CALC) ||
                    ((state_next == S_FIX) && !(accept && fast_hit) && !(state == S_FIX && fast_q));
            done <= (state_next == S_DONE);
            if (accept) begin
                fn      <= funct3;
                rd_q    <= rd_in;
                cnt     <= '1;
                fast_q  <= fast_hit;
                b_zero  <= (op_b == '0);
                neg_res <= a_neg ^ b_neg;
                neg_rem <= a_neg;
                opnd    <= is_div ? b_mag : a_mag;
                p       <= fast_hit ? {{XLEN{1'b0}}, fast_val}
                                    : {{XLEN{1'b0}}, (is_div ? a_mag : b_mag)};
            end else if (state == S_CALC) begin
                p   <= p_step;
                cnt <= cnt - CW'(1);
            end else if (state == S_FIX) begin
                result <= fix_val;
                rd_out <= rd_q;
            end
        end
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed corner cases plus random ops against an arithmetic model.
// Honours MULDIV_FASTPATH_EN for expected latency.
module tb_muldiv_unit;
    logic        clk = 1'b0;
    logic        reset, start;
    logic [2:0]  funct3;
    logic [63:0] op_a, op_b;
    logic [4:0]  rd_in;
    logic        busy, done;
    logic [63:0] result;
    logic [4:0]  rd_out;

    int          n_pass  = 0;
    int          n_total = 0;
    logic [63:0] exp_res;
    logic [4:0]  exp_rd;
    int          exp_lat;

    localparam logic [63:0] MINV = 64'h8000_0000_0000_0000;

    muldiv_unit #(.XLEN(64)) dut (
        .clk(clk), .reset(reset), .start(start), .funct3(funct3),
        .op_a(op_a), .op_b(op_b), .rd_in(rd_in),
        .busy(busy), .done(done), .result(result), .rd_out(rd_out)
    );

    always #5 clk = ~clk;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [63:0] model(input logic [2:0] f, input logic [63:0] a, input logic [63:0] b);
        logic signed [127:0] sa, sb, ua, ub, pr;
        sa = $signed(a);
        sb = $signed(b);
        ua = {64'd0, a};
        ub = {64'd0, b};
        case (f)
            3'd0: begin pr = ua * ub; return pr[63:0];   end
            3'd1: begin pr = sa * sb; return pr[127:64]; end
            3'd2: begin pr = sa * ub; return pr[127:64]; end
            3'd3: begin pr = ua * ub; return pr[127:64]; end
            3'd4: begin
                if (b == 64'd0) return '1;
                if (a == MINV && b == '1) return a;
                return $signed(a) / $signed(b);
            end
            3'd5: begin
                if (b == 64'd0) return '1;
                return a / b;
            end
            3'd6: begin
                if (b == 64'd0) return a;
                if (a == MINV && b == '1) return 64'd0;
                return $signed(a) % $signed(b);
            end
            default: begin
                if (b == 64'd0) return a;
                return a % b;
            end
        endcase
    endfunction

    function automatic bit is_fast(input logic [2:0] f, input logic [63:0] a, input logic [63:0] b);
`ifdef MULDIV_FASTPATH_EN
        return (b == 64'd0) || ((f == 3'd4 || f == 3'd6) && a == MINV && b == '1);
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [63:0] rnd64();
        case ($urandom_range(0, 6))
            0:       return 64'd0;
            1:       return '1;
            2:       return MINV;
            3:       return 64'($urandom_range(1, 20));
            4:       return -64'($urandom_range(1, 20));
            default: return {$urandom, $urandom};
        endcase
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic launch(input logic [2:0] f, input logic [63:0] a, input logic [63:0] b, input logic [4:0] rd);
        start   = 1'b1;
        funct3  = f;
        op_a    = a;
        op_b    = b;
        rd_in   = rd;
        exp_res = model(f, a, b);
        exp_rd  = rd;
        exp_lat = is_fast(f, a, b) ? 1 : 65;
    endtask

    task automatic wait_done(input string tag, input bit inject);
        int lat;
        @(negedge clk);
        start  = 1'b0;
        funct3 = 3'($urandom);
        op_a   = {$urandom, $urandom};
        op_b   = {$urandom, $urandom};
        rd_in  = 5'($urandom);
        check({tag, " busy"}, 64'(busy), 64'(exp_lat != 1));
        if (exp_lat != 1) check({tag, " done_low"}, 64'(done), 64'd0);
        lat = 0;
        while (done !== 1'b1 && lat < 200) begin
            if (inject && lat == 10) begin
                start  = 1'b1;
                funct3 = 3'($urandom);
                op_a   = {$urandom, $urandom};
                op_b   = {$urandom, $urandom};
                rd_in  = 5'($urandom);
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
        check({tag, " latency"}, 64'(lat), 64'(exp_lat));
        check({tag, " result"}, result, exp_res);
        check({tag, " rd_out"}, 64'(rd_out), 64'(exp_rd));
    endtask

    task automatic check_drop(input string tag);
        @(negedge clk);
        check({tag, " done_pulse"}, 64'(done), 64'd0);
    endtask

    task automatic run(input string tag, input logic [2:0] f, input logic [63:0] a,
                       input logic [63:0] b, input logic [4:0] rd);
        launch(f, a, b, rd);
        wait_done(tag, 1'b0);
        check_drop(tag);
    endtask

    initial begin
        int seen;
        reset  = 1'b0;
        start  = 1'b0;
        funct3 = '0;
        op_a   = '0;
        op_b   = '0;
        rd_in  = '0;
        repeat (2) @(negedge clk);
        check("rst busy", 64'(busy), 64'd0);
        check("rst done", 64'(done), 64'd0);
        check("rst result", result, 64'd0);
        check("rst rd_out", 64'(rd_out), 64'd0);

        reset = 1'b1;
        run("mulh", 3'd1, '1, 64'd2, 5'd1);
        run("mulhu", 3'd3, '1, 64'd2, 5'd2);
        run("mulhsu", 3'd2, '1, 64'd2, 5'd3);
        run("mul", 3'd0, 64'd3, 64'd5, 5'd4);
        run("div", 3'd4, -64'd7, 64'd2, 5'd5);
        run("rem", 3'd6, -64'd7, 64'd2, 5'd6);
        run("divu", 3'd5, 64'd7, 64'd2, 5'd7);
        run("remu", 3'd7, 64'd7, 64'd2, 5'd8);
        run("div_ovf", 3'd4, MINV, '1, 5'd9);
        run("rem_ovf", 3'd6, MINV, '1, 5'd10);
        run("divu_z", 3'd5, 64'd5, 64'd0, 5'd11);
        run("remu_z", 3'd7, 64'd5, 64'd0, 5'd12);
        run("div_z", 3'd4, -64'd5, 64'd0, 5'd13);
        run("rem_z", 3'd6, -64'd5, 64'd0, 5'd14);
        run("mul_z", 3'd0, 64'd9, 64'd0, 5'd15);

        // Abort a divide with an asynchronous reset between clock edges.
        launch(3'd4, 64'd1000, 64'd7, 5'd16);
        @(negedge clk);
        start = 1'b0;
        repeat (20) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        check("abort busy", 64'(busy), 64'd0);
        check("abort done", 64'(done), 64'd0);
        check("abort result", result, 64'd0);
        check("abort rd_out", 64'(rd_out), 64'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        seen = 0;
        repeat (80) begin
            @(negedge clk);
            if (done === 1'b1) seen++;
        end
        check("abort no_done", 64'(seen), 64'd0);
        run("post_abort_mul", 3'd0, 64'd3, 64'd5, 5'd17);

        // Start pulsed mid-CALC must be ignored.
        launch(3'd0, 64'h1234_5678_9abc_def0, 64'h0fed_cba9_8765_4321, 5'd18);
        wait_done("inject", 1'b1);
        check_drop("inject");

        // Back-to-back: second start during the done cycle.
        launch(3'd5, 64'd100, 64'd9, 5'd19);
        wait_done("b2b_first", 1'b0);
        launch(3'd6, -64'd100, 64'd9, 5'd20);
        wait_done("b2b_second", 1'b0);
        check_drop("b2b_second");

        for (int i = 0; i < 25; i++) begin
            run($sformatf("rand%0d", i), 3'($urandom), rnd64(), rnd64(), 5'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
